// File: rtl/change_dispenser_pkg.sv
// Shared constants and state encoding for the change dispenser.
package change_dispenser_pkg;

   localparam int K_TOTAL_BITS = 31;
   localparam int K_STOCK_BITS = 8;
   localparam int K_INIT_STOCK = 4;
   localparam int K_COIN0_VAL  = 100;
   localparam int K_COIN1_VAL  = 500;
   localparam int K_COIN2_VAL  = 1000;
   localparam int K_NUM_COINS  = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_ISSUE  = 2'd2,
      ST_DONE   = 2'd3
   } disp_state_t;

endpackage

// File: rtl/change_dispenser_stock.sv
// One saturating coin inventory counter; simultaneous inc and dec cancel out.
module change_coin_stock #(
   parameter int STOCK_BITS = 8,
   parameter int INIT_STOCK = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  inc,
   input  logic                  dec,
   output logic [STOCK_BITS-1:0] count,
   output logic                  zero
);

   localparam logic [STOCK_BITS-1:0] STOCK_MAX  = '1;
   localparam logic [STOCK_BITS-1:0] STOCK_INIT = STOCK_BITS'(INIT_STOCK);
   localparam logic [STOCK_BITS-1:0] STOCK_ONE  = STOCK_BITS'(1);

   // inventory update: refill saturates at max, dispense never wraps below zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= STOCK_INIT;
      end else if (inc && !dec) begin
         if (count != STOCK_MAX) count <= count + STOCK_ONE;
      end else if (dec && !inc) begin
         if (count != '0) count <= count - STOCK_ONE;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy change payout, one coin per hopper handshake, limited by inventory.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | waiting for start; latches start_total into amount
//  ST_SELECT | pick largest coin that fits amount and is in stock
//  ST_ISSUE  | coin_valid held until coin_ready; then deduct and reselect
//  ST_DONE   | one-cycle done pulse, remainder holds the unpaid amount
module change_dispenser
   import change_dispenser_pkg::*;
#(
   parameter int TOTAL_BITS = K_TOTAL_BITS,
   parameter int STOCK_BITS = K_STOCK_BITS,
   parameter int INIT_STOCK = K_INIT_STOCK,
   parameter int COIN0_VAL  = K_COIN0_VAL,
   parameter int COIN1_VAL  = K_COIN1_VAL,
   parameter int COIN2_VAL  = K_COIN2_VAL
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [TOTAL_BITS-1:0] start_total,
   input  logic                  coin_ready,
   input  logic                  refill_valid,
   input  logic [1:0]            refill_sel,
   output logic                  busy,
   output logic                  coin_valid,
   output logic [1:0]            coin_sel,
   output logic                  done,
   output logic [TOTAL_BITS-1:0] remainder
);

   // index 3 is an unused coin slot with value 0 so coin_sel can index safely
   localparam logic [3:0][TOTAL_BITS-1:0] COIN_VAL = {
      {TOTAL_BITS{1'b0}},
      TOTAL_BITS'(COIN2_VAL),
      TOTAL_BITS'(COIN1_VAL),
      TOTAL_BITS'(COIN0_VAL)
   };

   disp_state_t                         state, state_nxt;
   logic [TOTAL_BITS-1:0]               amount, amount_nxt, remainder_nxt;
   logic                                busy_nxt, coin_valid_nxt, done_nxt;
   logic [1:0]                          coin_sel_nxt;
   logic [K_NUM_COINS-1:0]              stock_inc, stock_dec, stock_zero;
   logic [K_NUM_COINS-1:0][STOCK_BITS-1:0] stock;
   logic                                pick_found;
   logic [1:0]                          pick_idx;
   logic                                accept;

   assign accept = (state == ST_ISSUE) && coin_valid && coin_ready;

   for (genvar k = 0; k < K_NUM_COINS; k++) begin : g_stock
      assign stock_inc[k] = refill_valid && (refill_sel == 2'(k));
      assign stock_dec[k] = accept && (coin_sel == 2'(k));
      change_coin_stock #(
         .STOCK_BITS (STOCK_BITS),
         .INIT_STOCK (INIT_STOCK)
      ) u_stock (
         .clk     (clk),
         .reset_n (reset_n),
         .inc     (stock_inc[k]),
         .dec     (stock_dec[k]),
         .count   (stock[k]),
         .zero    (stock_zero[k])
      );
   end

   // greedy pick: largest coin not exceeding amount with nonzero stock
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = 2'd0;
      for (int k = K_NUM_COINS - 1; k >= 0; k--) begin
         if (!pick_found && (amount >= COIN_VAL[k]) && !stock_zero[k]) begin
            pick_found = 1'b1;
            pick_idx   = 2'(k);
         end
      end
   end

   // next-state and next-output logic
   always_comb begin
      state_nxt      = state;
      amount_nxt     = amount;
      busy_nxt       = busy;
      coin_valid_nxt = coin_valid;
      coin_sel_nxt   = coin_sel;
      done_nxt       = 1'b0;
      remainder_nxt  = remainder;
      case (state)
         ST_IDLE: begin
            if (start) begin
               amount_nxt = start_total;
               busy_nxt   = 1'b1;
               state_nxt  = ST_SELECT;
            end
         end
         ST_SELECT: begin
            if (pick_found) begin
               coin_sel_nxt   = pick_idx;
               coin_valid_nxt = 1'b1;
               state_nxt      = ST_ISSUE;
            end else begin
               done_nxt      = 1'b1;
               remainder_nxt = amount;
               busy_nxt      = 1'b0;
               state_nxt     = ST_DONE;
            end
         end
         ST_ISSUE: begin
            if (coin_ready) begin
               if (amount >= COIN_VAL[coin_sel]) amount_nxt = amount - COIN_VAL[coin_sel];
               coin_valid_nxt = 1'b0;
               state_nxt      = ST_SELECT;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // state and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         amount     <= '0;
         busy       <= 1'b0;
         coin_valid <= 1'b0;
         coin_sel   <= 2'd0;
         done       <= 1'b0;
         remainder  <= '0;
      end else begin
         state      <= state_nxt;
         amount     <= amount_nxt;
         busy       <= busy_nxt;
         coin_valid <= coin_valid_nxt;
         coin_sel   <= coin_sel_nxt;
         done       <= done_nxt;
         remainder  <= remainder_nxt;
      end
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: payouts, inventory limits, stalls, refill, reset.
module tb_change_dispenser;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [30:0] start_total;
   logic        coin_ready;
   logic        refill_valid;
   logic [1:0]  refill_sel;
   logic        busy;
   logic        coin_valid;
   logic [1:0]  coin_sel;
   logic        done;
   logic [30:0] remainder;

   int checks   = 0;
   int failures = 0;

   change_dispenser dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .start_total  (start_total),
      .coin_ready   (coin_ready),
      .refill_valid (refill_valid),
      .refill_sel   (refill_sel),
      .busy         (busy),
      .coin_valid   (coin_valid),
      .coin_sel     (coin_sel),
      .done         (done),
      .remainder    (remainder)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      failures++;
      $display("FAIL %s timeout waiting on DUT", tag);
   endtask

   task automatic do_reset();
      reset_n      = 1'b0;
      start        = 1'b0;
      start_total  = '0;
      coin_ready   = 1'b0;
      refill_valid = 1'b0;
      refill_sel   = 2'd0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // Starts a payout with coin_ready tied high; seq holds expected coin indices, 2 bits each.
   task automatic payout(input string tag, input logic [30:0] amt, input int n_exp,
                         input logic [15:0] seq, input logic [30:0] rem_exp, input int lat_exp);
      int cyc;
      int n;
      bit got;
      logic [30:0] rem;
      cyc = 0; n = 0; got = 0; rem = '0;
      coin_ready  = 1'b1;
      start_total = amt;
      start       = 1'b1;
      while (!got && cyc < 200) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (cyc == 1) chk({tag, "_busy"}, 64'(busy), 64'd1);
         if (coin_valid) begin
            if (n < 8) chk({tag, "_sel"}, 64'(coin_sel), 64'(seq[2*n +: 2]));
            n++;
         end
         if (done) begin
            got = 1;
            rem = remainder;
         end
      end
      if (!got) timeout(tag);
      else begin
         chk({tag, "_ncoins"}, 64'(n), 64'(n_exp));
         chk({tag, "_rem"}, 64'(rem), 64'(rem_exp));
         if (lat_exp >= 0) chk({tag, "_latency"}, 64'(cyc), 64'(lat_exp));
      end
      @(negedge clk);
   endtask

   task automatic wait_valid(input string tag, output bit ok);
      int cyc;
      cyc = 0; ok = 0;
      while (!ok && cyc < 20) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (coin_valid) ok = 1;
      end
      if (!ok) timeout(tag);
   endtask

   task automatic wait_done(input string tag, output int ncoins, output logic [30:0] rem, output bit ok);
      int cyc;
      cyc = 0; ok = 0; ncoins = 0; rem = '0;
      while (!ok && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (coin_valid) ncoins++;
         if (done) begin
            ok  = 1;
            rem = remainder;
         end
      end
      if (!ok) timeout(tag);
   endtask

   initial begin
      bit          ok;
      int          nc;
      logic [30:0] rem;

      // reset state, observed while reset is held
      reset_n      = 1'b0;
      start        = 1'b0;
      start_total  = '0;
      coin_ready   = 1'b0;
      refill_valid = 1'b0;
      refill_sel   = 2'd0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valid", 64'(coin_valid), 64'd0);
      chk("rst_sel", 64'(coin_sel), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_rem", 64'(remainder), 64'd0);
      chk("rst_stock0", 64'(dut.stock[0]), 64'd4);
      chk("rst_stock2", 64'(dut.stock[2]), 64'd4);
      reset_n = 1'b1;
      @(negedge clk);

      // 1700 -> 1000, 500, 100, 100
      payout("t1", 31'd1700, 4, 16'({2'd0, 2'd0, 2'd1, 2'd2}), 31'd0, 10);
      chk("t1_stock2", 64'(dut.stock[2]), 64'd3);
      chk("t1_stock1", 64'(dut.stock[1]), 64'd3);
      chk("t1_stock0", 64'(dut.stock[0]), 64'd2);

      // zero amount: IDLE, SELECT, DONE
      payout("t0", 31'd0, 0, 16'd0, 31'd0, 2);
      chk("t0_busy_after", 64'(busy), 64'd0);

      // 350 -> three coin 0, 50 left
      do_reset();
      payout("t2", 31'd350, 3, 16'({2'd0, 2'd0, 2'd0}), 31'd50, 8);
      chk("t2_stock0", 64'(dut.stock[0]), 64'd1);

      // drain coin 1, then 900 can only use coin 0
      do_reset();
      for (int i = 0; i < 4; i++) payout("t3_500", 31'd500, 1, 16'd1, 31'd0, 4);
      chk("t3_stock1", 64'(dut.stock[1]), 64'd0);
      payout("t3_900", 31'd900, 4, 16'd0, 31'd500, -1);
      chk("t3_stock0", 64'(dut.stock[0]), 64'd0);
      payout("t3_empty", 31'd100, 0, 16'd0, 31'd100, 2);

      // hopper stall with start pulses while busy
      do_reset();
      coin_ready  = 1'b0;
      start_total = 31'd100;
      start       = 1'b1;
      wait_valid("t4_valid", ok);
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_valid", 64'(coin_valid), 64'd1);
         chk("t4_hold_sel", 64'(coin_sel), 64'd0);
         start       = (i == 1);
         start_total = 31'd1000;
         @(negedge clk);
      end
      start      = 1'b0;
      coin_ready = 1'b1;
      wait_done("t4_done", nc, rem, ok);
      if (ok) begin
         chk("t4_extra_coins", 64'(nc), 64'd0);
         chk("t4_rem", 64'(rem), 64'd0);
      end
      repeat (3) @(negedge clk);
      chk("t4_idle_valid", 64'(coin_valid), 64'd0);
      chk("t4_idle_busy", 64'(busy), 64'd0);
      chk("t4_stock0", 64'(dut.stock[0]), 64'd3);
      chk("t4_stock2", 64'(dut.stock[2]), 64'd4);

      // refill and dispense of coin 0 in the same cycle, then saturation
      do_reset();
      coin_ready  = 1'b0;
      start_total = 31'd100;
      start       = 1'b1;
      wait_valid("t5_valid", ok);
      coin_ready   = 1'b1;
      refill_valid = 1'b1;
      refill_sel   = 2'd0;
      @(negedge clk);
      refill_valid = 1'b0;
      chk("t5_net_stock0", 64'(dut.stock[0]), 64'd4);
      chk("t5_valid_drop", 64'(coin_valid), 64'd0);
      wait_done("t5_done", nc, rem, ok);
      if (ok) chk("t5_rem", 64'(rem), 64'd0);
      refill_sel = 2'd0;
      for (int i = 0; i < 251; i++) begin
         refill_valid = 1'b1;
         @(negedge clk);
      end
      refill_valid = 1'b0;
      chk("t5_stock0_full", 64'(dut.stock[0]), 64'd255);
      refill_valid = 1'b1;
      @(negedge clk);
      refill_valid = 1'b0;
      chk("t5_stock0_sat", 64'(dut.stock[0]), 64'd255);
      refill_sel   = 2'd3;
      refill_valid = 1'b1;
      @(negedge clk);
      refill_valid = 1'b0;
      chk("t5_sel3_stock1", 64'(dut.stock[1]), 64'd4);
      chk("t5_sel3_stock2", 64'(dut.stock[2]), 64'd4);

      // asynchronous reset in the middle of ISSUE
      do_reset();
      coin_ready  = 1'b0;
      start_total = 31'd1700;
      start       = 1'b1;
      wait_valid("t6_valid", ok);
      chk("t6_pre_busy", 64'(busy), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_async_valid", 64'(coin_valid), 64'd0);
      chk("t6_async_busy", 64'(busy), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("t6_stock0", 64'(dut.stock[0]), 64'd4);
      chk("t6_stock1", 64'(dut.stock[1]), 64'd4);
      chk("t6_stock2", 64'(dut.stock[2]), 64'd4);
      chk("t6_state", 64'(dut.state), 64'd0);
      payout("t6_after", 31'd100, 1, 16'd0, 31'd0, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
